// File: rtl/mem_instr_control_if.sv
// Control-strobe bundle between the memory-instruction sequencer and the datapath.
interface mem_instr_control_if;
  logic [4:0] ir_op;
  logic       mem_ready;
  logic       run;
  logic       fault;
  logic       read;
  logic       write;
  logic       MARin;
  logic       MDRin;
  logic       MDRout;
  logic       PCout;
  logic       PCin;
  logic       incPC;
  logic       IRin;
  logic       Yin;
  logic       Zin;
  logic       ZLowOut;
  logic       Cout;
  logic       BAout;
  logic       Gra;
  logic       Grb;
  logic       Rin;
  logic       Rout;
  logic [4:0] opcode;

  modport master (
    input  ir_op, mem_ready,
    output run, fault, read, write, MARin, MDRin, MDRout, PCout, PCin, incPC, IRin,
           Yin, Zin, ZLowOut, Cout, BAout, Gra, Grb, Rin, Rout, opcode
  );

  modport slave (
    output ir_op, mem_ready,
    input  run, fault, read, write, MARin, MDRin, MDRout, PCout, PCin, incPC, IRin,
           Yin, Zin, ZLowOut, Cout, BAout, Gra, Grb, Rin, Rout, opcode
  );
endinterface

// File: rtl/mem_instr_control.sv
// T-state sequencer for fetch and ld/ldi/st; memory waits in T1, LD6 and ST7 with timeout to HALT.
module mem_instr_control #(
  parameter int         WAIT_MAX = 15,
  parameter logic [4:0] ALU_ADD  = 5'b00001
) (
  input  logic                 clk,
  input  logic                 clr,
  mem_instr_control_if.master  bus
);
  localparam int CNT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5,
    S_LDI5, S_LD6, S_LD7, S_ST6, S_ST7, S_HALT
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             fault_q;
  logic             is_wait;
  logic             timeout;
  logic             mem_class;

  assign is_wait   = (state == S_T1) || (state == S_LD6) || (state == S_ST7);
  // mem_ready arriving on the last allowed cycle still completes the access
  assign timeout   = is_wait && !bus.mem_ready && (wait_cnt == CNT_LAST);
  assign mem_class = (bus.ir_op == OP_LD) || (bus.ir_op == OP_LDI) || (bus.ir_op == OP_ST);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= S_RESET;
      wait_cnt <= '0;
      fault_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        wait_cnt <= '0;
      else if (is_wait && !bus.mem_ready)
        wait_cnt <= wait_cnt + CNT_W'(1);
      if (timeout)
        fault_q <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_RESET: state_nxt = S_T0;
      S_T0:    state_nxt = S_T1;
      S_T1:    state_nxt = bus.mem_ready ? S_T2 : (timeout ? S_HALT : S_T1);
      S_T2:    state_nxt = S_T3;
      S_T3: begin
        if (mem_class)                 state_nxt = S_T4;
        else if (bus.ir_op == OP_HALT) state_nxt = S_HALT;
        else                           state_nxt = S_T0;
      end
      S_T4:    state_nxt = (bus.ir_op == OP_LDI) ? S_LDI5 : S_T5;
      S_LDI5:  state_nxt = S_T0;
      S_T5:    state_nxt = (bus.ir_op == OP_ST) ? S_ST6 : S_LD6;
      S_LD6:   state_nxt = bus.mem_ready ? S_LD7 : (timeout ? S_HALT : S_LD6);
      S_LD7:   state_nxt = S_T0;
      S_ST6:   state_nxt = S_ST7;
      S_ST7:   state_nxt = bus.mem_ready ? S_T0 : (timeout ? S_HALT : S_ST7);
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_RESET;
    endcase
  end

  always_comb begin
    bus.run     = (state != S_RESET) && (state != S_HALT);
    bus.fault   = fault_q;
    bus.read    = 1'b0;
    bus.write   = 1'b0;
    bus.MARin   = 1'b0;
    bus.MDRin   = 1'b0;
    bus.MDRout  = 1'b0;
    bus.PCout   = 1'b0;
    bus.PCin    = 1'b0;
    bus.incPC   = 1'b0;
    bus.IRin    = 1'b0;
    bus.Yin     = 1'b0;
    bus.Zin     = 1'b0;
    bus.ZLowOut = 1'b0;
    bus.Cout    = 1'b0;
    bus.BAout   = 1'b0;
    bus.Gra     = 1'b0;
    bus.Grb     = 1'b0;
    bus.Rin     = 1'b0;
    bus.Rout    = 1'b0;
    bus.opcode  = 5'b00000;
    case (state)
      S_T0:   begin bus.PCout = 1'b1; bus.MARin = 1'b1; bus.incPC = 1'b1; bus.Zin = 1'b1; end
      S_T1:   begin bus.ZLowOut = 1'b1; bus.PCin = 1'b1; bus.read = 1'b1; bus.MDRin = 1'b1; end
      S_T2:   begin bus.MDRout = 1'b1; bus.IRin = 1'b1; end
      S_T3:   if (mem_class) begin bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1; end
      S_T4:   begin bus.Cout = 1'b1; bus.Zin = 1'b1; bus.opcode = ALU_ADD; end
      S_LDI5: begin bus.ZLowOut = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
      S_T5:   begin bus.ZLowOut = 1'b1; bus.MARin = 1'b1; end
      S_LD6:  begin bus.read = 1'b1; bus.MDRin = 1'b1; end
      S_LD7:  begin bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
      S_ST6:  begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.MDRin = 1'b1; end
      S_ST7:  bus.write = 1'b1;
      default: ;
    endcase
  end
endmodule
